sysid_checker: RTL and testbench

Avalon-MM read master that sits directly upstream of the system ID slave and consumes its output. After reset, and on request, it reads the ID word (address 0) and the timestamp word (address 1), holds both values, and compares them against expected constants. It gives boot logic and debug LEDs a single registered pass/fail indication, so the hardware/software image mismatch check does not depend on the CPU.

---
 rtl/sysid_checker.sv | 176 +++++++++++++++++
 tb/tb_sysid_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID word
// (address 0) and timestamp word (address 1), compares both against the
// expected constants and holds a registered pass/fail result.
// Optional macro SYSID_CHECK_PERIODIC_EN adds an automatic recheck every
// REFRESH_PERIOD cycles spent in DONE.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1457125450,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned REFRESH_PERIOD     = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        recheck,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        done,
  output logic        match,
  output logic        error,
  output logic [7:0]  mismatch_count
);

  typedef enum logic [1:0] {RD_ID, RD_TS, COMPARE, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        av_read_q, av_read_d;
  logic        av_address_q, av_address_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        error_q, error_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        recheck_go;

`ifdef SYSID_CHECK_PERIODIC_EN
  logic [31:0] refresh_q, refresh_d;
  logic        refresh_hit;

  // Idle counter in DONE; issues an internal recheck at the end of the period
  always_comb begin
    refresh_hit = (state_q == DONE) && (refresh_q == 32'(REFRESH_PERIOD - 1));
    refresh_d   = '0;
    if (state_q == DONE && !recheck_go) refresh_d = refresh_q + 32'd1;
  end

  // Refresh counter register
  always_ff @(posedge clock) begin
    if (reset) refresh_q <= '0;
    else       refresh_q <= refresh_d;
  end

  // An external and an internal request in the same cycle merge into one
  assign recheck_go = (state_q == DONE) && (recheck || refresh_hit);
`else
  logic [31:0] unused_refresh;
  assign unused_refresh = 32'(REFRESH_PERIOD);
  assign recheck_go     = (state_q == DONE) && recheck;
`endif

  // Next-state and registered-output computation
  always_comb begin
    logic xfer_done;
    logic stall;
    logic [7:0] mcnt_inc;
    logic abort;

    state_d      = state_q;
    av_read_d    = av_read_q;
    av_address_d = av_address_q;
    id_d         = id_q;
    ts_d         = ts_q;
    done_d       = done_q;
    match_d      = match_q;
    error_d      = error_q;
    mcnt_d       = mcnt_q;
    tcnt_d       = tcnt_q;

    xfer_done = av_read_q && !av_waitrequest;
    stall     = av_read_q && av_waitrequest;
    mcnt_inc  = (mcnt_q == 8'hFF) ? mcnt_q : mcnt_q + 8'd1;
    abort     = stall && (tcnt_q == TO_LAST);

    case (state_q)
      RD_ID, RD_TS: begin
        av_read_d    = 1'b1;
        av_address_d = (state_q == RD_TS);
        if (xfer_done) begin
          tcnt_d = '0;
          if (state_q == RD_ID) begin
            id_d         = av_readdata;
            av_address_d = 1'b1;
            state_d      = RD_TS;
          end else begin
            ts_d      = av_readdata;
            av_read_d = 1'b0;
            state_d   = COMPARE;
          end
        end else if (abort) begin
          // Abort skips COMPARE so that the failed check is counted exactly once
          av_read_d = 1'b0;
          error_d   = 1'b1;
          match_d   = 1'b0;
          done_d    = 1'b1;
          mcnt_d    = mcnt_inc;
          tcnt_d    = '0;
          state_d   = DONE;
        end else if (stall) begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      COMPARE: begin
        av_read_d = 1'b0;
        match_d   = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
        if (!((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP))) mcnt_d = mcnt_inc;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (recheck_go) begin
          done_d       = 1'b0;
          match_d      = 1'b0;
          error_d      = 1'b0;
          av_read_d    = 1'b1;
          av_address_d = 1'b0;
          state_d      = RD_ID;
        end
      end
      default: state_d = RD_ID;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RD_ID;
      av_read_q    <= 1'b0;
      av_address_q <= 1'b0;
      id_q         <= '0;
      ts_q         <= '0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      error_q      <= 1'b0;
      mcnt_q       <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      av_read_q    <= av_read_d;
      av_address_q <= av_address_d;
      id_q         <= id_d;
      ts_q         <= ts_d;
      done_q       <= done_d;
      match_q      <= match_d;
      error_q      <= error_d;
      mcnt_q       <= mcnt_d;
      tcnt_q       <= tcnt_d;
    end
  end

  assign av_read        = av_read_q;
  assign av_address     = av_address_q;
  assign id_value       = id_q;
  assign ts_value       = ts_q;
  assign done           = done_q;
  assign match          = match_q;
  assign error          = error_q;
  assign mismatch_count = mcnt_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a default instance driven by a
// zero-latency slave model, and a TIMEOUT_CYCLES=8 instance whose slave
// never releases waitrequest.
module tb_sysid_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance 0: default parameters
  logic        rst0, recheck0, wr0;
  logic        addr0, rd0;
  logic [31:0] rdata0, id0, ts0, ts_ret;
  logic        done0, match0, err0;
  logic [7:0]  mcnt0;

  // Instance 1: short timeout, stalled slave
  logic        rst1, recheck1, wr1;
  logic        addr1, rd1;
  logic [31:0] rdata1, id1, ts1;
  logic        done1, match1, err1;
  logic [7:0]  mcnt1;

  assign rdata0 = addr0 ? ts_ret : 32'h0;
  assign rdata1 = addr1 ? 32'h56D9F84A : 32'h12345678;

  sysid_checker #(.REFRESH_PERIOD(16)) dut0 (
    .clock(clock), .reset(rst0), .recheck(recheck0),
    .av_address(addr0), .av_read(rd0), .av_waitrequest(wr0), .av_readdata(rdata0),
    .id_value(id0), .ts_value(ts0), .done(done0), .match(match0), .error(err0),
    .mismatch_count(mcnt0));

  sysid_checker #(.TIMEOUT_CYCLES(8), .REFRESH_PERIOD(16)) dut1 (
    .clock(clock), .reset(rst1), .recheck(recheck1),
    .av_address(addr1), .av_read(rd1), .av_waitrequest(wr1), .av_readdata(rdata1),
    .id_value(id1), .ts_value(ts1), .done(done1), .match(match1), .error(err1),
    .mismatch_count(mcnt1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_recheck0();
    recheck0 = 1'b1;
    tick();
    recheck0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, done0}, 32'd1);
  endtask

  initial begin
    int cnt;
    rst0 = 1'b1; rst1 = 1'b1;
    recheck0 = 1'b0; recheck1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b1;
    ts_ret = 32'h56D9F84A;
    tick(); tick();

    // Reset state
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_read",  {31'd0, rd0},   32'd0);
    check("rst_match", {31'd0, match0}, 32'd0);
    check("rst_error", {31'd0, err0},  32'd0);
    check("rst_mcnt",  {24'd0, mcnt0}, 32'd0);
    check("rst_id",    id0, 32'd0);
    check("rst_ts",    ts0, 32'd0);

    // Check after reset release, no wait states
    rst0 = 1'b0;
    tick();  // N
    check("n0_read", {31'd0, rd0},   32'd1);
    check("n0_addr", {31'd0, addr0}, 32'd0);
    check("n0_done", {31'd0, done0}, 32'd0);
    tick();  // N+1
    check("n1_addr", {31'd0, addr0}, 32'd1);
    check("n1_read", {31'd0, rd0},   32'd1);
    tick();  // N+2
    check("n2_read", {31'd0, rd0},   32'd0);
    check("n2_ts",   ts0, 32'h56D9F84A);
    check("n2_done", {31'd0, done0}, 32'd0);
    tick();  // N+3
    check("n3_done",  {31'd0, done0}, 32'd1);
    check("n3_match", {31'd0, match0}, 32'd1);
    check("n3_error", {31'd0, err0},  32'd0);
    check("n3_id",    id0, 32'd0);
    check("n3_mcnt",  {24'd0, mcnt0}, 32'd0);

    // Recheck in DONE
    pulse_recheck0();
    check("rc_done",  {31'd0, done0},  32'd0);
    check("rc_read",  {31'd0, rd0},    32'd1);
    check("rc_addr",  {31'd0, addr0},  32'd0);
    check("rc_match", {31'd0, match0}, 32'd0);
    wait_done0("rc_wait");
    check("rc_match2", {31'd0, match0}, 32'd1);

    // Timestamp mismatch
    ts_ret = 32'h56D9F84B;
    pulse_recheck0();
    wait_done0("mm_wait");
    check("mm_match", {31'd0, match0}, 32'd0);
    check("mm_mcnt",  {24'd0, mcnt0}, 32'd1);
    check("mm_ts",    ts0, 32'h56D9F84B);

    // Saturation after 300 more mismatching checks
    for (int i = 0; i < 300; i++) begin
      pulse_recheck0();
      cnt = 0;
      while (done0 !== 1'b1 && cnt < 40) begin
        tick();
        cnt++;
      end
    end
    check("sat_done", {31'd0, done0}, 32'd1);
    check("sat_mcnt", {24'd0, mcnt0}, 32'd255);

    // Recheck outside DONE is ignored, not queued
    ts_ret = 32'h56D9F84A;
    pulse_recheck0();
    recheck0 = 1'b1;
    tick();
    recheck0 = 1'b0;
    wait_done0("nq_wait");
    tick(); tick(); tick();
    check("nq_done", {31'd0, done0}, 32'd1);
    check("nq_read", {31'd0, rd0},   32'd0);
    check("nq_mcnt", {24'd0, mcnt0}, 32'd255);

    // Three wait states during the ID read
    rst0 = 1'b1;
    tick();
    check("ws_rst_mcnt", {24'd0, mcnt0}, 32'd0);
    rst0 = 1'b0; wr0 = 1'b1;
    tick(); tick(); tick(); tick();  // N .. N+3
    check("ws_hold_read", {31'd0, rd0},   32'd1);
    check("ws_hold_addr", {31'd0, addr0}, 32'd0);
    wr0 = 1'b0;
    tick(); tick();  // N+4, N+5
    check("ws_n5_done", {31'd0, done0}, 32'd0);
    tick();  // N+6
    check("ws_n6_done",  {31'd0, done0},  32'd1);
    check("ws_n6_match", {31'd0, match0}, 32'd1);
    check("ws_n6_error", {31'd0, err0},   32'd0);

    // Reset while in RD_TS
    ts_ret = 32'h56D9F84B;
    pulse_recheck0();
    wait_done0("pre_wait");
    check("pre_mcnt", {24'd0, mcnt0}, 32'd1);
    ts_ret = 32'h56D9F84A;
    pulse_recheck0();  // RD_ID
    tick();            // RD_TS
    check("rts_addr", {31'd0, addr0}, 32'd1);
    rst0 = 1'b1;
    tick();
    check("rts_read", {31'd0, rd0},   32'd0);
    check("rts_done", {31'd0, done0}, 32'd0);
    check("rts_mcnt", {24'd0, mcnt0}, 32'd0);
    rst0 = 1'b0;
    tick(); tick(); tick();
    check("rts_n2_done", {31'd0, done0}, 32'd0);
    tick();
    check("rts_n3_done",  {31'd0, done0},  32'd1);
    check("rts_n3_match", {31'd0, match0}, 32'd1);

    // Timeout instance: waitrequest never drops
    rst1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && done1 !== 1'b1; i++) begin
      tick();
      if (rd1 === 1'b1) cnt++;
    end
    check("to_read_cycles", cnt, 32'd8);
    check("to_done",  {31'd0, done1},  32'd1);
    check("to_error", {31'd0, err1},   32'd1);
    check("to_match", {31'd0, match1}, 32'd0);
    check("to_read",  {31'd0, rd1},    32'd0);
    check("to_id",    id1, 32'd0);
    check("to_mcnt",  {24'd0, mcnt1},  32'd1);

    // Behaviour while parked in DONE
    pulse_recheck0();
    wait_done0("per_wait");
`ifdef SYSID_CHECK_PERIODIC_EN
    cnt = 0;
    while (done0 === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("per_cycles", cnt, 32'd16);
    check("per_read",   {31'd0, rd0}, 32'd1);
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done0 !== 1'b1 || rd0 !== 1'b0) cnt++;
    end
    check("park_drops", cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
